// File: rtl/bus_arbiter_rr_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_pkg
// Shared definitions for the system-bus round-robin arbiter.
//   - ENABLE_ / DISABLE_ : levels of active-low bus strobes (req_, lock_, grnt_)
//   - BUS_MASTER_n       : master index constants
//   - BUS_ARB_OWNER_W(n) : owner-index width for n masters (at least 1 bit)
//   - HOLD_MAX_DEFAULT   : default per-grant hold quota
//   - HOLD_CNT_W         : width of the hold counter
// ---------------------------------------------------------------------------
`ifndef BUS_ARBITER_RR_PKG_SV
`define BUS_ARBITER_RR_PKG_SV

`define BUS_ARB_OWNER_W(n) (((n) > 1) ? $clog2(n) : 1)

package bus_arbiter_rr_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BUS_MASTER_0  = 0;  localparam int BUS_MASTER_1  = 1;
    localparam int BUS_MASTER_2  = 2;  localparam int BUS_MASTER_3  = 3;
    localparam int BUS_MASTER_4  = 4;  localparam int BUS_MASTER_5  = 5;
    localparam int BUS_MASTER_6  = 6;  localparam int BUS_MASTER_7  = 7;
    localparam int BUS_MASTER_8  = 8;  localparam int BUS_MASTER_9  = 9;
    localparam int BUS_MASTER_10 = 10; localparam int BUS_MASTER_11 = 11;
    localparam int BUS_MASTER_12 = 12; localparam int BUS_MASTER_13 = 13;
    localparam int BUS_MASTER_14 = 14; localparam int BUS_MASTER_15 = 15;

    localparam int HOLD_MAX_DEFAULT = 16;
    localparam int HOLD_CNT_W       = 8;

endpackage

`endif

// File: rtl/bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr_pick
// Combinational rotate-priority finder. Scans start+1, start+2, ... wrapping
// modulo N and ends with start itself, reporting the first set request.
//   req        in  N      request vector, active-high
//   start      in  IDX_W  index the scan rotates from
//   excl_start in  1      leave start itself out of the scan
//   found      out 1      some eligible request was found
//   idx        out IDX_W  index of that request (0 when none found)
// ---------------------------------------------------------------------------
module bus_arbiter_rr_pick
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = `BUS_ARB_OWNER_W(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    input  logic             excl_start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int pos;

    // Walk offsets from farthest to nearest so the nearest hit is the one
    // left standing; offset N is start itself.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(start) + k) % N;
            if (req[pos[IDX_W-1:0]] && !(excl_start && (k == N))) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
// Round-robin arbiter for the shared system bus. One master always owns the
// bus; with no requests the grant parks on the last owner.
// Optional feature macro: BUS_ARB_QUOTA_EN adds the per-grant hold quota
// (hold counter, quota expiry and lock_ honouring). Without it an owner
// keeps the bus for as long as it requests.
//   clk     in   1            rising-edge clock
//   rst     in   1            synchronous reset, active-high
//   req_    in   NUM_MASTERS  bus requests, active-low
//   lock_   in   NUM_MASTERS  lock, active-low, honoured for the owner only
//   grnt_   out  NUM_MASTERS  grant, one-hot-low, decoded from owner register
//   owner   out  OWNER_W      index of the granted master
//   switch  out  1            high in the first cycle of a new owner
// ---------------------------------------------------------------------------
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int HOLD_MAX    = HOLD_MAX_DEFAULT,
    parameter int OWNER_W     = `BUS_ARB_OWNER_W(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_,
    input  logic [NUM_MASTERS-1:0] lock_,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   switch
);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic                   switch_q, switch_d;
    logic                   owner_req, others_req;
    logic                   pick_found;
    logic [OWNER_W-1:0]     pick_idx;
    logic                   quota_exp;

    assign req = ~req_;

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign owner_req  = req[owner_q];
    assign others_req = |(req & ~owner_oh);

    // While the owner still requests, the scan must skip it so an expiring
    // quota hands the bus to someone else; otherwise its bit is already 0.
    bus_arbiter_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (OWNER_W)
    ) u_pick (
        .req        (req),
        .start      (owner_q),
        .excl_start (owner_req),
        .found      (pick_found),
        .idx        (pick_idx)
    );

`ifdef BUS_ARB_QUOTA_EN
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);

    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  owner_locked;
    logic                  contended;

    assign owner_locked = (lock_[owner_q] == ENABLE_);
    assign contended    = owner_req && others_req;
    assign quota_exp    = contended && !owner_locked && (hold_cnt_q == HOLD_LAST);

    // Counter only advances while the owner is actually being contested and
    // not locked; it stays saturated at HOLD_LAST so a lock release expires
    // the quota on the very next edge.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (owner_d != owner_q) begin
            hold_cnt_d = '0;
        end else if (contended && !owner_locked && (hold_cnt_q < HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign quota_exp  = 1'b0;
    assign unused_cfg = (^lock_) ^ (HOLD_MAX > 0);
`endif

    always_comb begin
        owner_d = owner_q;
        if ((!owner_req || quota_exp) && pick_found) begin
            owner_d = pick_idx;
        end
        switch_d = (owner_d != owner_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWNER_W'(BUS_MASTER_0);
            switch_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            switch_q <= switch_d;
        end
    end

    // Grant is a plain decode of the owner register: no path from req_.
    always_comb begin
        grnt_          = {NUM_MASTERS{DISABLE_}};
        grnt_[owner_q] = ENABLE_;
    end

    assign owner  = owner_q;
    assign switch = switch_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

    localparam int N    = 4;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [1:0] owner;
        logic       sw;
        logic [3:0] grnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_;
    logic [3:0] lock_;
    logic [3:0] grnt_;
    logic [1:0] owner;
    logic       sw_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // reference model state
    int m_owner = 0;
    int m_hold  = 0;

    bus_arbiter_rr #(
        .NUM_MASTERS (N),
        .HOLD_MAX    (HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_   (req_),
        .lock_  (lock_),
        .grnt_  (grnt_),
        .owner  (owner),
        .switch (sw_o)
    );

    always #5 clk = ~clk;

    function automatic logic bit_at(input logic [3:0] v, input int i);
        return v[i[1:0]];
    endfunction

    // Drive one cycle of stimulus, predict the post-edge outputs, then
    // compare after the edge.
    task automatic drive(input string tag, input logic r, input logic [3:0] rq, input logic [3:0] lk);
        int   nxt;
        int   first;
        logic own_r;
        logic oth;
        logic sw;
        exp_t e;
        @(negedge clk);
        rst   = r;
        req_  = rq;
        lock_ = lk;
        if (r) begin
            nxt    = 0;
            m_hold = 0;
            sw     = 1'b0;
        end else begin
            own_r = !bit_at(rq, m_owner);
            oth   = 1'b0;
            first = -1;
            for (int d = 1; d < N; d++) begin
                int j;
                j = (m_owner + d) % N;
                if (!bit_at(rq, j)) begin
                    oth = 1'b1;
                    if (first < 0) first = j;
                end
            end
            nxt = m_owner;
            if (!own_r && first >= 0) nxt = first;
`ifdef BUS_ARB_QUOTA_EN
            if (own_r && oth && bit_at(lk, m_owner) && m_hold == HOLD - 1) nxt = first;
            if (nxt != m_owner) m_hold = 0;
            else if (own_r && oth && bit_at(lk, m_owner) && m_hold < HOLD - 1) m_hold++;
`endif
            sw = (nxt != m_owner);
        end
        m_owner = nxt;
        e.owner = 2'(nxt);
        e.sw    = sw;
        e.grnt  = 4'b1111 & ~(4'b0001 << nxt);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (owner === e.owner) else begin
            errors++;
            $error("FAIL %s owner observed %0d expected %0d", tag, owner, e.owner);
        end
        checks++;
        assert (grnt_ === e.grnt) else begin
            errors++;
            $error("FAIL %s grnt_ observed %b expected %b", tag, grnt_, e.grnt);
        end
        checks++;
        assert (sw_o === e.sw) else begin
            errors++;
            $error("FAIL %s switch observed %b expected %b", tag, sw_o, e.sw);
        end
    endtask

    task automatic spot_owner(input string tag, input logic [1:0] exp_v);
        checks++;
        assert (owner === exp_v) else begin
            errors++;
            $error("FAIL %s owner observed %0d expected %0d", tag, owner, exp_v);
        end
    endtask

    task automatic spot_grnt(input string tag, input logic [3:0] exp_v);
        checks++;
        assert (grnt_ === exp_v) else begin
            errors++;
            $error("FAIL %s grnt_ observed %b expected %b", tag, grnt_, exp_v);
        end
    endtask

    localparam logic [3:0] NONE = 4'b1111;

`ifdef BUS_ARB_QUOTA_EN
    localparam logic [1:0] Q_ROT = 2'd2;
`else
    localparam logic [1:0] Q_ROT = 2'd0;
`endif

    initial begin
        rst   = 1'b1;
        req_  = NONE;
        lock_ = NONE;

        // reset and idle
        repeat (2) drive("reset", 1'b1, NONE, NONE);
        repeat (10) drive("idle", 1'b0, NONE, NONE);
        spot_owner("reset_owner", 2'd0);
        spot_grnt("reset_grnt", 4'b1110);

        // rotation and wrap-around
        drive("rot_own0", 1'b0, 4'b1110, NONE);
        drive("rot_1and3", 1'b0, 4'b0101, NONE);
        spot_owner("rot_to_1", 2'd1);
        drive("rot_1and3", 1'b0, 4'b0101, NONE);
        drive("rot_only3", 1'b0, 4'b0111, NONE);
        spot_owner("rot_to_3", 2'd3);
        drive("rot_only0", 1'b0, 4'b1110, NONE);
        spot_owner("wrap_to_0", 2'd0);

        // quota: masters 0 and 2 contend
        repeat (3) drive("quota", 1'b0, 4'b1010, NONE);
        spot_owner("quota_hold0", 2'd0);
        drive("quota", 1'b0, 4'b1010, NONE);
        spot_owner("quota_rotate", Q_ROT);
        repeat (8) drive("quota", 1'b0, 4'b1010, NONE);
`ifndef BUS_ARB_QUOTA_EN
        spot_owner("no_quota_keep0", 2'd0);
`endif

        // lock: owner 0 reaches saturation, then locks for 10 cycles
        repeat (2) drive("lock_prep", 1'b0, 4'b1110, NONE);
        repeat (3) drive("lock_sat", 1'b0, 4'b1010, NONE);
        repeat (10) drive("locked", 1'b0, 4'b1010, 4'b1110);
        spot_owner("lock_kept0", 2'd0);
        drive("lock_release", 1'b0, 4'b1010, NONE);
        spot_owner("lock_release", Q_ROT);

        // parking on master 2
        repeat (2) drive("park_get2", 1'b0, 4'b1011, NONE);
        repeat (3) drive("parked", 1'b0, NONE, NONE);
        spot_owner("park_owner", 2'd2);
        spot_grnt("park_grnt", 4'b1011);
        drive("park_to_1", 1'b0, 4'b1101, NONE);
        spot_owner("park_to_1", 2'd1);

        // reset while master 3 owns with a saturated counter
        drive("mid_get3", 1'b0, 4'b0111, NONE);
        repeat (3) drive("mid_sat", 1'b0, 4'b0110, NONE);
        spot_owner("mid_owner3", 2'd3);
        drive("mid_reset", 1'b1, 4'b0110, NONE);
        spot_owner("mid_reset_owner", 2'd0);
        spot_grnt("mid_reset_grnt", 4'b1110);
        repeat (3) drive("post_reset", 1'b0, 4'b0110, NONE);
        spot_owner("post_reset_hold", 2'd0);
        drive("post_reset", 1'b0, 4'b0110, NONE);
`ifdef BUS_ARB_QUOTA_EN
        spot_owner("post_reset_rot", 2'd3);
`else
        spot_owner("post_reset_keep", 2'd0);
`endif

        // random traffic
        for (int i = 0; i < 60; i++) begin
            logic [3:0] rq;
            logic [3:0] lk;
            rq = 4'($urandom);
            lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : NONE;
            drive("random", 1'b0, rq, lk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised round-robin bus arbiter for the shared system bus, the successor to the fixed four-master arbiter. It grants exactly one of NUM_MASTERS masters at all times and parks the grant on the last owner when no master requests. It adds a per-grant hold quota so a streaming master cannot starve others, plus owner/switch status for the bus multiplexers and performance counters.

## Interface
- NUM_MASTERS, 4: number of masters, 2..16.
- HOLD_MAX, 16: maximum consecutive cycles an owner keeps the bus under contention, 1..255; used only with the quota feature.
- OWNER_W, $clog2(NUM_MASTERS): owner index width, derived.

- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_  in  NUM_MASTERS  per-master bus request, active-low, bit i = master i.
- lock_  in  NUM_MASTERS  per-master lock, active-low; honoured only for the current owner.
- grnt_  out  NUM_MASTERS  per-master grant, active-low, one-hot-low, registered.
- owner  out  OWNER_W  index of the granted master, registered.
- switch  out  1  one-cycle pulse, high in the first cycle of a new owner.

## Operation
- Reset: owner=0; grnt_ has bit0=0 and all other bits=1; switch=0; hold_cnt=0.
- Exactly one grnt_ bit is low in every cycle after reset. The grant is a pure decode of the owner register, with no combinational path from req_.
- States, implicit in owner and request:
  - OWNED: the owner's req_ is low.
  - PARKED: the owner's req_ is high.
- Next-owner rule, evaluated each edge with no reset:
  - Owner's req_ low and quota not expired: owner is kept.
  - Owner's req_ high: the first requesting master scanning owner+1, owner+2 … wrapping modulo NUM_MASTERS becomes owner. If no master requests, owner is kept (PARKED).
  - Quota expired, meaning the owner is requesting, another master is requesting, hold_cnt==HOLD_MAX-1, and the owner's lock_ is high: the first requesting master scanning from owner+1, excluding the owner, becomes owner.
- hold_cnt (8 bit):
  - Cleared to 0 on an owner change.
  - Incremented when the owner requests and at least one other master requests.
  - Held otherwise, including when uncontended and when locked.
  - Saturates at HOLD_MAX-1.
- Owner lock_ low suppresses quota expiry. The owner dropping req_ still releases the bus regardless of lock.
- switch=1 in the cycle after any owner change, otherwise 0.
- Reset asserted mid-transfer forces the reset values on the next edge, overriding everything.

## Timing
- Latency: a req_ sampled low at edge k on a PARKED bus gives grnt_ low after edge k, one cycle.
- Release: the owner deasserts req_ before edge k; the new grant is visible after edge k. There is no dead cycle between owners.
- Under contention with quota, the owner holds at most HOLD_MAX consecutive cycles, then rotates.
- Simultaneous requests from several non-owners are resolved by rotation order from the current owner, never by fixed index.
- Worst-case wait for a requester is (NUM_MASTERS-1)*HOLD_MAX cycles when no master locks.

## Configuration
- BUS_ARB_QUOTA_EN defined: hold_cnt, the quota expiry rule and lock_ honouring are present.
- Undefined: no counter is built, lock_ is ignored, and an owner keeps the bus as long as its req_ is low, matching the previous generation's behaviour, generalised to N masters.

## Structure
- Shared bus package holds:
  - ENABLE_/DISABLE_ active-low constants.
  - The BUS_MASTER_n index constants.
  - The owner-index width macro.
  - The default HOLD_MAX.
- One sub-module, rr_pick: combinational rotate-priority finder.
  - Inputs: request vector (active-high), start index, exclude-start flag.
  - Outputs: found flag and index.
  - Instantiated once.

## Test plan
- Reset, N=4: rst=1 for 2 cycles, then no requests. Required: owner=0, grnt_=4'b1110, switch=0, held for 10 cycles.
- Rotation: owner=0 drops, masters 1 and 3 request. Required: owner=1 next cycle. When master 1 drops, owner=3. Master 0 requesting alone afterwards gives owner=0 (wrap-around).
- Quota, HOLD_MAX=4: masters 0 and 2 request continuously. Required: owner alternates 0→2→0 every 4 cycles, with a switch pulse on each change.
- Lock: same as the quota scenario, but master 0 holds lock_ low for 10 cycles. Required: owner stays 0 for those 10 cycles, then switches to 2 on the first edge after lock_ rises, since hold_cnt is saturated.
- Parking: owner=2 drops req_ with no other requests. Required: owner stays 2, grnt_=4'b1011, no switch pulse. Master 1 then requests and gets owner=1 one cycle later.
- Mid-operation reset: rst=1 while owner=3 with a saturated hold_cnt. Required: after the edge, owner=0, grnt_=4'b1110, switch=0, hold_cnt=0. Macro off: repeat the quota scenario and check that master 0 is never preempted.
